switch_debouncer: RTL and testbench
===================================

# switch_debouncer

Input-conditioning stage between the board switches (`ui_in`) and the adder datapath. It synchronises each switch bit into `clk` and debounces it with a per-channel stability counter. It presents clean levels plus one-cycle rise/fall pulses, so the downstream half-adder stage sees glitch-free operands and a strobe when they change.

## Interface
- `WIDTH`, 8: number of independent switch channels.
- `DEBOUNCE_CYCLES`, 50_000: N, the consecutive cycles an input must hold a new level before it is accepted (5 ms at 10 MHz). Legal range 1..2^CNT_W−1.
- `CNT_W`, 16: counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `RESET_VAL`, {WIDTH{1'b0}}: value of `sw_stable` after reset.

Ports:
- `clk`, input, 1: single clock; all state on rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `ena`, input, 1: design enable; low freezes debounce counters.
- `sw_in`, input, WIDTH: raw asynchronous switch levels.
- `sw_stable`, output, WIDTH: debounced levels, registered.
- `sw_rise`, output, WIDTH: one-cycle pulse when the channel's `sw_stable` goes 0→1.
- `sw_fall`, output, WIDTH: one-cycle pulse when the channel's `sw_stable` goes 1→0.
- `sw_any`, output, 1: OR of `sw_rise | sw_fall`, registered alongside them.

## Operation
- Per channel: two-flop synchroniser `s1`→`s2` (reset 0), then FSM {IDLE, PENDING} with counter `cnt` (reset 0).
- IDLE: `s2 == sw_stable`. `cnt` = 0. On `s2 != sw_stable` → PENDING, `cnt` ← 1. If N == 1, accept immediately instead.
- PENDING:
  - If `s2 == sw_stable`, the glitch is rejected: → IDLE, `cnt` ← 0, no pulse.
  - Else if `cnt == N−1`: `sw_stable` ← `s2`, the matching rise/fall pulse is asserted, → IDLE, `cnt` ← 0.
  - Else `cnt` ← `cnt`+1.
- `ena` low: synchronisers keep running; FSM state, `cnt` and `sw_stable` hold; pulses forced 0.
- Channels are fully independent. Simultaneous changes on several channels each complete on their own schedule, and may pulse in the same cycle.
- Reset values: `sw_stable` = RESET_VAL; `sw_rise`, `sw_fall` and `sw_any` = 0; all `cnt` = 0; all FSMs in IDLE.
- `rst` asserted mid-count: everything is cleared immediately (async). Any pending change is discarded and no pulse is produced.

## Timing
- Input settles before edge 1. `s1` captures it at edge 1, `s2` at edge 2. Mismatch is counted over edges 3..N+2, and `sw_stable` updates at edge N+2.
- Total latency from stable input to `sw_stable` change: N+2 rising edges. With N=1 this is 3 edges, i.e. a plain synchroniser plus one register.
- `sw_rise` / `sw_fall` / `sw_any` are high for exactly the one cycle following the edge that updates `sw_stable`.
- Rejection: a pulse that survives in `s2` for fewer than N cycles causes no output change.
- A bounce during PENDING restarts the count from scratch at the next mismatch.
- `cnt` never exceeds N−1, so there is no wrap-around.
- `ena` deasserted for k cycles during PENDING extends latency by exactly k.

## Structure
- The shared package `tt_pkg` holds `DEBOUNCE_DEFAULT` (50_000) and the FSM state enum `dbn_state_t` {IDLE, PENDING}.
- Sub-module `debounce_channel`: one bit holding synchroniser, FSM, counter and pulse registers. `switch_debouncer` instantiates it WIDTH times in a generate loop and ORs the pulses into `sw_any`.

## Test plan
Benches run with N=4 and WIDTH=8.
1. Reset check: assert `rst` with `sw_in`=8'hFF, then release. `sw_stable` = 8'h00 and all pulses 0 at release. Then `sw_stable` = 8'hFF exactly 6 edges after the first clocked edge, with `sw_rise`=8'hFF and `sw_any`=1 for one cycle.
2. Glitch rejection: hold `sw_in[0]`=1 for 3 cycles, then 0. `sw_stable[0]` stays 0 and no pulse occurs. Repeat with 4 cycles: `sw_stable[0]`=1 at edge 6.
3. Bounce mid-count: toggle bit 1 as 1,1,0,1,1,1,1. Acceptance occurs 4 stable cycles after the last bounce, and `sw_rise[1]` pulses exactly once.
4. Enable freeze: with a change on bit 2 pending, after `cnt`=2 drop `ena` for 5 cycles. `sw_stable[2]` changes 5 edges later than the nominal N+2, and no pulse occurs while `ena`=0.
5. Async reset mid-count: assert `rst` between edges while bit 3 is PENDING. Outputs go to reset values without a clock edge, and no `sw_fall` / `sw_rise` follows release unless the input is re-qualified.
6. Independent channels: change bits 0 and 1 in the same cycle and bit 7 two cycles later. Bits 0 and 1 pulse together, and bit 7 pulses two cycles after them.

Source files
------------

// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared constants and debounce FSM state type
package tt_pkg;

  localparam int DEBOUNCE_DEFAULT = 50_000;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } dbn_state_t;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one switch bit: two-flop synchroniser, stability FSM/counter, edge pulses
module debounce_channel
  import tt_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int   CNT_W           = 16,
  parameter logic RESET_BIT       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic sw_in,
  output logic sw_stable,
  output logic sw_rise,
  output logic sw_fall,
  output logic accept
);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  dbn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    s1_d     = sw_in;
    s2_d     = s1_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    accept   = 1'b0;

    // Synchroniser keeps sampling while disabled; only the qualifier freezes.
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (s2_q != stable_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              accept = 1'b1;
            end else begin
              state_d = PENDING;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        PENDING: begin
          if (s2_q == stable_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            accept = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (accept) begin
      stable_d = s2_q;
      rise_d   = s2_q;
      fall_d   = ~s2_q;
      state_d  = IDLE;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      stable_q <= RESET_BIT;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign sw_stable = stable_q;
  assign sw_rise   = rise_q;
  assign sw_fall   = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - WIDTH independent debounced switch channels with rise/fall strobes
module switch_debouncer
  import tt_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int               CNT_W           = 16,
  parameter logic [WIDTH-1:0] RESET_VAL       = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_any
);

  logic [WIDTH-1:0] accept;
  logic             sw_any_q, sw_any_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .RESET_BIT      (RESET_VAL[i])
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .sw_in    (sw_in[i]),
      .sw_stable(sw_stable[i]),
      .sw_rise  (sw_rise[i]),
      .sw_fall  (sw_fall[i]),
      .accept   (accept[i])
    );
  end

  // Any accepted change this cycle becomes a pulse next cycle, in step with sw_rise/sw_fall.
  always_comb begin
    sw_any_d = |accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_any_q <= 1'b0;
    end else begin
      sw_any_q <= sw_any_d;
    end
  end

  assign sw_any = sw_any_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - randomized and directed checks of switch_debouncer against a run-length model
module tb_switch_debouncer;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ena = 1'b1;
  logic [W-1:0] sw_in = '0;
  logic [W-1:0] sw_stable, sw_rise, sw_fall;
  logic         sw_any;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  logic [W-1:0] m_s1, m_s2, m_stb, m_rise, m_fall;
  logic         m_any;
  int           m_run [W];

  switch_debouncer #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(N),
    .CNT_W          (16),
    .RESET_VAL      ('0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .sw_in    (sw_in),
    .sw_stable(sw_stable),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .sw_any   (sw_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stb = '0;
    m_rise = '0; m_fall = '0; m_any = 1'b0;
    for (int c = 0; c < W; c++) m_run[c] = 0;
  endtask

  // A level is accepted once N enabled edges in a row have seen the synchronised input differ.
  task automatic model_step();
    m_rise = '0; m_fall = '0;
    if (ena) begin
      for (int c = 0; c < W; c++) begin
        if (m_s2[c] != m_stb[c]) m_run[c] = m_run[c] + 1;
        else                     m_run[c] = 0;
        if (m_run[c] == N) begin
          m_stb[c]  = m_s2[c];
          m_rise[c] = m_s2[c];
          m_fall[c] = ~m_s2[c];
          m_run[c]  = 0;
        end
      end
    end
    m_any = |(m_rise | m_fall);
    m_s2 = m_s1;
    m_s1 = sw_in;
  endtask

  task automatic cyc(input logic [W-1:0] v, input logic en);
    sw_in = v;
    ena   = en;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("stable", 32'(sw_stable), 32'(m_stb));
      chk("rise",   32'(sw_rise),   32'(m_rise));
      chk("fall",   32'(sw_fall),   32'(m_fall));
      chk("any",    32'(sw_any),    32'(m_any));
    end
  end

  initial begin
    int first0, first1, first7, first2, cnt_r;
    logic [W-1:0] cur, mask;

    model_reset();
    sw_in = 8'hFF;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_en = 1'b1;
    rst = 1'b0;
    chk("reset_stable", 32'(sw_stable), 32'h00);
    chk("reset_pulses", 32'({sw_rise, sw_fall, 7'd0, sw_any}), 32'h0);

    for (int k = 1; k <= 7; k++) begin
      cyc(8'hFF, 1'b1);
      if (k == 5) chk("pre_accept_stable", 32'(sw_stable), 32'h00);
      if (k == 6) begin
        chk("edge6_stable", 32'(sw_stable), 32'hFF);
        chk("edge6_rise",   32'(sw_rise),   32'hFF);
        chk("edge6_any",    32'(sw_any),    32'h1);
      end
      if (k == 7) chk("edge7_rise", 32'(sw_rise), 32'h00);
    end
    for (int k = 0; k < 8; k++) cyc(8'h00, 1'b1);
    chk("all_fell", 32'(sw_stable), 32'h00);

    cnt_r = 0;
    for (int k = 1; k <= 11; k++) begin
      cyc((k <= 3) ? 8'h01 : 8'h00, 1'b1);
      if (sw_rise[0]) cnt_r++;
    end
    chk("glitch3_stable", 32'(sw_stable[0]), 32'h0);
    chk("glitch3_pulses", 32'(cnt_r), 32'd0);

    for (int k = 1; k <= 6; k++) begin
      cyc((k <= 4) ? 8'h01 : 8'h00, 1'b1);
      if (k == 5) chk("hold4_pre", 32'(sw_stable[0]), 32'h0);
      if (k == 6) chk("hold4_accept", 32'(sw_stable[0]), 32'h1);
    end
    for (int k = 0; k < 8; k++) cyc(8'h00, 1'b1);

    first1 = 0; cnt_r = 0;
    for (int k = 1; k <= 14; k++) begin
      cyc((k == 3) ? 8'h00 : 8'h02, 1'b1);
      if (sw_rise[1]) begin
        cnt_r++;
        if (first1 == 0) first1 = k;
      end
    end
    chk("bounce_accept_edge", 32'(first1), 32'd9);
    chk("bounce_rise_count", 32'(cnt_r), 32'd1);
    for (int k = 0; k < 8; k++) cyc(8'h00, 1'b1);

    first2 = 0;
    for (int k = 1; k <= 14; k++) begin
      cyc(8'h04, !(k >= 5 && k <= 9));
      if (sw_stable[2] && first2 == 0) first2 = k;
    end
    chk("ena_freeze_edge", 32'(first2), 32'd11);
    for (int k = 0; k < 8; k++) cyc(8'h00, 1'b1);

    for (int k = 0; k < 8; k++) cyc(8'h30, 1'b1);
    for (int k = 0; k < 4; k++) cyc(8'h38, 1'b1);
    #2;
    rst = 1'b1;
    sw_in = 8'h00;
    model_reset();
    #1;
    chk("async_stable", 32'(sw_stable), 32'h00);
    chk("async_pulses", 32'({sw_rise, sw_fall, 7'd0, sw_any}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cnt_r = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(8'h00, 1'b1);
      if (sw_any) cnt_r++;
    end
    chk("post_reset_no_pulse", 32'(cnt_r), 32'd0);

    first0 = 0; first1 = 0; first7 = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc(((k >= 1) ? 8'h03 : 8'h00) | ((k >= 3) ? 8'h80 : 8'h00), 1'b1);
      if (sw_rise[0] && first0 == 0) first0 = k;
      if (sw_rise[1] && first1 == 0) first1 = k;
      if (sw_rise[7] && first7 == 0) first7 = k;
    end
    chk("indep_bit0", 32'(first0), 32'd6);
    chk("indep_bit1", 32'(first1), 32'd6);
    chk("indep_bit7", 32'(first7), 32'd8);

    cur = 8'h83;
    for (int k = 0; k < 3000; k++) begin
      mask = 8'($urandom) & 8'($urandom) & 8'($urandom);
      cur  = cur ^ mask;
      cyc(cur, ($urandom_range(0, 9) != 0));
    end

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
